// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - shared funct3 codes, FSM state encoding and decode helper for mul_ctrl
// Purpose: RV32M multiply funct3 constants, 2-bit controller state type, funct3 validity check.
// Ports: none (package).
package mul_ctrl_pkg;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;

  typedef enum logic [1:0] {
    MULC_IDLE = 2'd0,
    MULC_BUSY = 2'd1,
    MULC_DONE = 2'd2
  } mulc_state_e;

  function automatic logic is_mul_f3(input logic [2:0] f3);
    return (f3 == MUL_F3) || (f3 == MULH_F3) || (f3 == MULHSU_F3) || (f3 == MULHU_F3);
  endfunction

endpackage

// File: rtl/mul_opnd_cond.sv
// rtl/mul_opnd_cond.sv - operand conditioning for the shift-add multiplier
// Purpose: decode per-operand signedness from funct3, convert signed operands to
//          magnitudes and produce the product-negate flag.
// Ports:
//   funct3     in   multiply variant
//   op1, op2   in   raw rs1/rs2 values
//   s1, s2     out  operand treated as signed
//   mag1, mag2 out  operand magnitudes fed to the multiplier
//   neg        out  product must be negated
module mul_opnd_cond
  import mul_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            s1,
  output logic            s2,
  output logic [XLEN-1:0] mag1,
  output logic [XLEN-1:0] mag2,
  output logic            neg
);

  logic neg1;
  logic neg2;

  always_comb begin
    s1   = (funct3 == MULH_F3) || (funct3 == MULHSU_F3);
    s2   = (funct3 == MULH_F3);
    neg1 = s1 & op1[XLEN-1];
    neg2 = s2 & op2[XLEN-1];
    // The most negative value negates onto itself, which is exactly its
    // unsigned magnitude, so no special case is needed.
    mag1 = neg1 ? (~op1 + XLEN'(1)) : op1;
    mag2 = neg2 ? (~op2 + XLEN'(1)) : op2;
    neg  = neg1 ^ neg2;
  end

endmodule

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - sequencing controller between EX and the iterative shift-add multiplier
// Purpose: accept RV32M multiply requests, short-circuit zero operands and repeated
//          operand pairs via a one-entry product cache, otherwise start the multiplier,
//          stall EX until the result is ready and handle flush/cancel.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid_i/req_funct3_i/
//   req_op1_i/req_op2_i              request from EX (held while stall_o)
//   flush_i                          pipeline flush
//   stall_o                          hold EX and upstream
//   res_valid_o, res_data_o          one-cycle result pulse and held result
//   mul_start_o, mul_cancel_o        multiplier control pulses
//   mul_signed_o, mul_op1_o,
//   mul_op2_o                        conditioned operands for the multiplier
//   mul_stop_i, mul_res_l_i,
//   mul_res_h_i                      multiplier completion and product
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_op1_i,
  input  logic [XLEN-1:0] req_op2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_data_o,
  output logic            mul_start_o,
  output logic            mul_cancel_o,
  output logic            mul_signed_o,
  output logic [XLEN-1:0] mul_op1_o,
  output logic [XLEN-1:0] mul_op2_o,
  input  logic            mul_stop_i,
  input  logic [XLEN-1:0] mul_res_l_i,
  input  logic [XLEN-1:0] mul_res_h_i
);

  mulc_state_e state_q, state_d;

  logic              cache_valid_q;
  logic [2*XLEN-1:0] cache_prod_q;
  logic [XLEN-1:0]   tag1_q;
  logic [XLEN-1:0]   tag2_q;
  logic [1:0]        tag_sign_q;
  logic [XLEN-1:0]   res_data_q;

  logic            s1, s2, neg;
  logic [XLEN-1:0] mag1, mag2;

  logic            live;
  logic            zero_op;
  logic            hit;
  logic            sel_hi;
  logic [XLEN-1:0] cache_half;
  logic [XLEN-1:0] mul_half;

  logic            res_load;
  logic [XLEN-1:0] res_next;
  logic            cache_wr;
  logic            start;
  logic            cancel;
  logic            res_valid;

  mul_opnd_cond #(.XLEN(XLEN)) u_opnd (
    .funct3 (req_funct3_i),
    .op1    (req_op1_i),
    .op2    (req_op2_i),
    .s1     (s1),
    .s2     (s2),
    .mag1   (mag1),
    .mag2   (mag2),
    .neg    (neg)
  );

  // Gating with rst_n keeps every output at zero while reset is held, even if
  // EX keeps presenting a request.
  assign live       = req_valid_i & rst_n;
  assign zero_op    = (req_op1_i == '0) || (req_op2_i == '0);
  // MUL's low half does not depend on signedness, so it may reuse any cached pair.
  assign hit        = CACHE_EN && cache_valid_q &&
                      (req_op1_i == tag1_q) && (req_op2_i == tag2_q) &&
                      ((req_funct3_i == MUL_F3) || ({s1, s2} == tag_sign_q));
  assign sel_hi     = (req_funct3_i != MUL_F3);
  assign cache_half = sel_hi ? cache_prod_q[2*XLEN-1:XLEN] : cache_prod_q[XLEN-1:0];
  assign mul_half   = sel_hi ? mul_res_h_i : mul_res_l_i;

  always_comb begin
    state_d   = state_q;
    res_load  = 1'b0;
    res_next  = '0;
    cache_wr  = 1'b0;
    start     = 1'b0;
    cancel    = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      MULC_IDLE: begin
        if (live && is_mul_f3(req_funct3_i) && !flush_i) begin
          if (zero_op) begin
            res_load = 1'b1;
            res_next = '0;
            state_d  = MULC_DONE;
          end else if (hit) begin
            res_load = 1'b1;
            res_next = cache_half;
            state_d  = MULC_DONE;
          end else begin
            start   = 1'b1;
            state_d = MULC_BUSY;
          end
        end
      end
      MULC_BUSY: begin
        if (flush_i) begin
          cancel  = 1'b1;
          state_d = MULC_IDLE;
        end else if (mul_stop_i) begin
          res_load = 1'b1;
          res_next = mul_half;
          cache_wr = 1'b1;
          state_d  = MULC_DONE;
        end
      end
      MULC_DONE: begin
        res_valid = !flush_i;
        state_d   = MULC_IDLE;
      end
      default: state_d = MULC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MULC_IDLE;
      res_data_q    <= '0;
      cache_valid_q <= 1'b0;
      cache_prod_q  <= '0;
      tag1_q        <= '0;
      tag2_q        <= '0;
      tag_sign_q    <= '0;
    end else begin
      state_q <= state_d;
      if (res_load) begin
        res_data_q <= res_next;
      end
      if (cache_wr) begin
        cache_valid_q <= 1'b1;
        cache_prod_q  <= {mul_res_h_i, mul_res_l_i};
        tag1_q        <= req_op1_i;
        tag2_q        <= req_op2_i;
        tag_sign_q    <= {s1, s2};
      end
    end
  end

  assign stall_o      = live & (state_q != MULC_DONE) & !flush_i;
  assign res_valid_o  = res_valid;
  assign res_data_o   = res_data_q;
  assign mul_start_o  = start;
  assign mul_cancel_o = cancel;
  assign mul_signed_o = live ? neg  : 1'b0;
  assign mul_op1_o    = live ? mag1 : '0;
  assign mul_op2_o    = live ? mag2 : '0;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - self-checking bench for mul_ctrl
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'd0;
  logic [31:0] req_op1_i = 32'd0;
  logic [31:0] req_op2_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        stall_o, res_valid_o, mul_start_o, mul_cancel_o, mul_signed_o;
  logic [31:0] res_data_o, mul_op1_o, mul_op2_o;
  logic        mul_stop_i;
  logic [31:0] mul_res_l_i, mul_res_h_i;

  int n_pass = 0;
  int n_total = 0;
  int start_cnt = 0;
  int resv_cnt = 0;

  // multiplier model state
  logic        smp_start = 1'b0, smp_cancel = 1'b0, smp_sgn = 1'b0;
  logic [31:0] smp_a = 32'd0, smp_b = 32'd0;
  logic        mb_busy = 1'b0;
  int          mb_cnt = 0;
  logic [63:0] model_prod = 64'd0;
  logic        model_stop = 1'b0;
  logic        extra_stop = 1'b0;

  // cache model
  logic        c_valid = 1'b0;
  logic [31:0] c1 = 32'd0, c2 = 32'd0;
  logic [1:0]  csign = 2'd0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        start;
    logic        sgn;
    logic [31:0] m1;
    logic [31:0] m2;
  } vec_t;
  vec_t tbl[8];

  assign mul_stop_i  = model_stop | extra_stop;
  assign mul_res_l_i = model_prod[31:0];
  assign mul_res_h_i = model_prod[63:32];

  always #5 clk = ~clk;

  mul_ctrl #(.XLEN(32), .CACHE_EN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_funct3_i (req_funct3_i),
    .req_op1_i    (req_op1_i),
    .req_op2_i    (req_op2_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .res_valid_o  (res_valid_o),
    .res_data_o   (res_data_o),
    .mul_start_o  (mul_start_o),
    .mul_cancel_o (mul_cancel_o),
    .mul_signed_o (mul_signed_o),
    .mul_op1_o    (mul_op1_o),
    .mul_op2_o    (mul_op2_o),
    .mul_stop_i   (mul_stop_i),
    .mul_res_l_i  (mul_res_l_i),
    .mul_res_h_i  (mul_res_h_i)
  );

  always @(negedge clk) begin
    smp_start  = mul_start_o;
    smp_cancel = mul_cancel_o;
    smp_sgn    = mul_signed_o;
    smp_a      = mul_op1_o;
    smp_b      = mul_op2_o;
    if (mul_start_o) start_cnt++;
    if (res_valid_o) resv_cnt++;
  end

  // 32-cycle multiplier: done 33 cycles after the start cycle
  always @(posedge clk) begin
    #1;
    model_stop = 1'b0;
    if (!rst_n) mb_busy = 1'b0;
    else if (smp_cancel) mb_busy = 1'b0;
    else if (smp_start) begin
      mb_busy = 1'b1;
      mb_cnt = 1;
      model_prod = {32'd0, smp_a} * {32'd0, smp_b};
      if (smp_sgn) model_prod = -model_prod;
    end else if (mb_busy) begin
      mb_cnt++;
      if (mb_cnt == 33) begin
        model_stop = 1'b1;
        mb_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_start, input logic exp_sgn,
                        input logic [31:0] m1, input logic [31:0] m2, input string nm);
    int   lat;
    int   s0;
    logic seen, stall_ok;
    s0 = start_cnt;
    req_valid_i = 1'b1;
    req_funct3_i = f3;
    req_op1_i = a;
    req_op2_i = b;
    @(negedge clk);
    chk({nm, "_start"}, 64'(mul_start_o), 64'(exp_start));
    chk({nm, "_sgn"}, 64'(mul_signed_o), 64'(exp_sgn));
    chk({nm, "_mag1"}, 64'(mul_op1_o), 64'(m1));
    chk({nm, "_mag2"}, 64'(mul_op2_o), 64'(m2));
    lat = 0;
    seen = 1'b0;
    stall_ok = 1'b1;
    while (!seen && lat < 60) begin
      if (res_valid_o) seen = 1'b1;
      else begin
        if (!stall_o) stall_ok = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
    chk({nm, "_latency"}, 64'(lat), exp_start ? 64'd34 : 64'd1);
    chk({nm, "_data"}, 64'(res_data_o), 64'(exp_res));
    chk({nm, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({nm, "_stall_done"}, 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    chk({nm, "_nstart"}, 64'(start_cnt - s0), 64'(exp_start));
    if (exp_start) begin
      c_valid = 1'b1;
      c1 = a;
      c2 = b;
      csign = {(f3 == 3'd1 || f3 == 3'd2), (f3 == 3'd1)};
    end
  endtask

  // expectations derived from the arithmetic rules and the cache model
  task automatic model_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string nm);
    logic s1, s2, n1, n2, hit, zero;
    logic [31:0] m1, m2;
    s1 = (f3 == 3'd1 || f3 == 3'd2);
    s2 = (f3 == 3'd1);
    n1 = s1 && a[31];
    n2 = s2 && b[31];
    m1 = n1 ? 32'd0 - a : a;
    m2 = n2 ? 32'd0 - b : b;
    zero = (a == 32'd0) || (b == 32'd0);
    hit = c_valid && a == c1 && b == c2 && (f3 == 3'd0 || {s1, s2} == csign);
    run_op(f3, a, b, ref_mul(f3, a, b), !zero && !hit, n1 ^ n2, m1, m2, nm);
  endtask

  initial begin
    int r0;
    logic [2:0]  f3;
    logic [31:0] a, b;
    int rs;

    tbl[0] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[1] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000002, 32'h00000003};
    tbl[2] = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000003};
    tbl[3] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFF};
    tbl[4] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1, 1'b0, 32'h80000000, 32'h80000000};
    tbl[5] = '{3'd0, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h12345678, 32'h00000000};
    tbl[6] = '{3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 32'h80000000, 32'h80000000};
    tbl[7] = '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1, 1'b0, 32'h80000000, 32'h80000000};

    // reset with a request presented: everything must read zero
    req_valid_i = 1'b1;
    req_funct3_i = 3'd1;
    req_op1_i = 32'hFFFFFFFF;
    req_op2_i = 32'h80000000;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_resv", 64'(res_valid_o), 64'd0);
    chk("rst_data", 64'(res_data_o), 64'd0);
    chk("rst_start", 64'(mul_start_o), 64'd0);
    chk("rst_cancel", 64'(mul_cancel_o), 64'd0);
    chk("rst_ops", {mul_op1_o, mul_op2_o}, 64'd0);
    chk("rst_sgn", 64'(mul_signed_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].start, tbl[i].sgn,
             tbl[i].m1, tbl[i].m2, $sformatf("vec%0d", i));

    // invalid funct3 is not a request
    r0 = resv_cnt;
    req_valid_i = 1'b1;
    req_funct3_i = 3'b101;
    req_op1_i = 32'd3;
    req_op2_i = 32'd5;
    @(negedge clk);
    chk("badf3_start", 64'(mul_start_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    chk("badf3_resv", 64'(resv_cnt - r0), 64'd0);

    // flush during DONE suppresses the result pulse
    req_valid_i = 1'b1;
    req_funct3_i = 3'd0;
    req_op1_i = 32'd0;
    req_op2_i = 32'd5;
    @(negedge clk);
    chk("dflush_start", 64'(mul_start_o), 64'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("dflush_resv", 64'(res_valid_o), 64'd0);
    chk("dflush_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("dflush_after", 64'(res_valid_o), 64'd0);
    @(posedge clk);
    #1;

    // flush while busy cancels the multiplier, then a re-issue misses the cache
    r0 = resv_cnt;
    req_valid_i = 1'b1;
    req_funct3_i = 3'd3;
    req_op1_i = 32'd5;
    req_op2_i = 32'd7;
    @(negedge clk);
    chk("bflush_start", 64'(mul_start_o), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("bflush_cancel", 64'(mul_cancel_o), 64'd1);
    chk("bflush_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("bflush_nores", 64'(resv_cnt - r0), 64'd0);
    run_op(3'd3, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0, 32'd5, 32'd7, "reissue");

    // mul_stop_i outside BUSY is ignored (low half would read 35)
    req_funct3_i = 3'd0;
    extra_stop = 1'b1;
    @(negedge clk);
    chk("stray_stop_resv", 64'(res_valid_o), 64'd0);
    @(posedge clk);
    #1;
    extra_stop = 1'b0;
    @(negedge clk);
    chk("stray_stop_resv2", 64'(res_valid_o), 64'd0);
    chk("stray_stop_data", 64'(res_data_o), 64'd0);
    @(posedge clk);
    #1;

    // reset in the middle of a multiply invalidates the cache
    run_op(3'd3, 32'd3, 32'h80000000, 32'd1, 1'b1, 1'b0, 32'd3, 32'h80000000, "prerst");
    req_valid_i = 1'b1;
    req_funct3_i = 3'd1;
    req_op1_i = 32'd3;
    req_op2_i = 32'h80000000;
    @(negedge clk);
    chk("midrst_start", 64'(mul_start_o), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_data", 64'(res_data_o), 64'd0);
    chk("midrst_ops", {mul_op1_o, mul_op2_o}, 64'd0);
    chk("midrst_sgn", 64'(mul_signed_o), 64'd0);
    chk("midrst_start0", 64'(mul_start_o), 64'd0);
    chk("midrst_resv", 64'(res_valid_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid_i = 1'b0;
    c_valid = 1'b0;
    @(posedge clk);
    #1;
    run_op(3'd0, 32'd3, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'd3, 32'h80000000, "postrst");

    // randomized traffic against the arithmetic/cache model
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 3));
      rs = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (rs < 3 && c_valid) begin
        a = c1;
        b = c2;
      end else if (rs == 3) a = 32'd0;
      else if (rs == 4) b = 32'd0;
      else if (rs == 5) a = 32'h80000000;
      model_op(f3, a, b, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative 32-cycle shift-add multiplier.
- Decodes the RV32M MUL/MULH/MULHSU/MULHU variants.
- Converts signed operands to magnitudes and tells the multiplier whether to negate the product.
- Stalls the pipeline while a multiply runs, handles flush/cancel, and short-circuits zero operands and repeated operand pairs (MULH followed by MUL) through a one-entry product cache.

Parameters:
XLEN, 32, operand/result width; must equal the register bus width in defines.v
CACHE_EN, 1, 1 enables the one-entry 2*XLEN product cache; 0 forces every non-zero request through the multiplier

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  1  EX holds a multiply instruction; held stable while stall_o=1
req_funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other codes ignored (no request)
req_op1_i  input  XLEN  rs1 value
req_op2_i  input  XLEN  rs2 value
flush_i  input  1  pipeline flush; kills any in-flight multiply
stall_o  output  1  hold EX/upstream stages
res_valid_o  output  1  one-cycle pulse, result on res_data_o
res_data_o  output  XLEN  selected product half
mul_start_o  output  1  one-cycle start pulse to multiplier
mul_cancel_o  output  1  one-cycle cancel pulse to multiplier
mul_signed_o  output  1  negate-product flag sampled with start
mul_op1_o  output  XLEN  multiplicand magnitude
mul_op2_o  output  XLEN  multiplier magnitude
mul_stop_i  input  1  multiplier done; product valid this cycle
mul_res_l_i  input  XLEN  product low half
mul_res_h_i  input  XLEN  product high half

Behaviour:
- Reset: state IDLE, cache invalid, res_data_o=0, and every output is 0.
- Signedness: s1=1 for MULH/MULHSU; s2=1 for MULH only. MUL uses s1=s2=0.
- Magnitudes and negation: neg1=s1&op1[XLEN-1], neg2=s2&op2[XLEN-1]. mag = neg ? (~op+1) : op. 0x80000000 maps to 0x80000000 unsigned. mul_signed_o=neg1^neg2.
- Half select: MUL selects the low half; the other three variants select the high half.
- mul_op1_o, mul_op2_o and mul_signed_o are combinational from the request whenever req_valid_i=1; otherwise 0.
- State IDLE, request accepted when req_valid_i & valid funct3 & !flush_i:
  - If op1==0 or op2==0: register result 0 and go to DONE (no start).
  - Else if CACHE_EN & cache valid & op1==tag1 & op2==tag2 & (funct3==MUL or {s1,s2}==tag_sign): register the selected half of the cached product and go to DONE (no start).
  - Else: assert mul_start_o this cycle and go to BUSY.
- State BUSY, in priority order:
  - flush_i: assert mul_cancel_o this cycle, go to IDLE, no result, cache unchanged.
  - mul_stop_i: register the selected half. Write the cache with {mul_res_h_i, mul_res_l_i}, tags op1/op2 and tag_sign={s1,s2}, valid=1. Go to DONE.
- State DONE:
  - res_valid_o=1 unless flush_i, which suppresses it.
  - Always return to IDLE.
  - No new request is accepted in DONE; the next instruction is accepted in the following IDLE cycle.
- stall_o = req_valid_i & (state!=DONE) & !flush_i.
- Latency, with request at cycle T:
  - Multiplier path: start at T, mul_stop_i at T+33, res_valid_o at T+34.
  - Zero or cache-hit path: res_valid_o at T+1.
- res_data_o holds its last value between results.
- Reset mid-BUSY: returns to IDLE with the cache invalid. The multiplier is reset by the same rst_n, so no cancel is needed.
- mul_stop_i while not BUSY is ignored.
- Cache is not written on zero-operand or hit paths, and is never invalidated by flush.

Decomposition:
- defines.v gains:
  - funct3 constants MUL_F3, MULH_F3, MULHSU_F3, MULHU_F3.
  - State encodings MULC_IDLE, MULC_BUSY, MULC_DONE (2-bit).
- One natural sub-module, mul_opnd_cond: combinational s1/s2 decode, neg1/neg2, magnitudes, and the negate flag.
- The FSM, cache and output select stay in mul_ctrl.

Test Plan:
- MULHU 0xFFFFFFFF x 0xFFFFFFFF: mul_start_o at T, mul_signed_o=0, res_valid_o at T+34 with 0xFFFFFFFE; stall_o high T..T+33.
- MULH 0xFFFFFFFE(-2) x 3: mag1=2, mul_signed_o=1, result 0xFFFFFFFF. Then MUL with the same operands: cache hit, no mul_start_o, res_valid_o one cycle later with 0xFFFFFFFA.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF: neg1=1, neg2=0, result 0xFFFFFFFF. MULH 0x80000000 x 0x80000000: mags 0x80000000, mul_signed_o=0, result 0x40000000.
- MUL 0x12345678 x 0: no start, res_valid_o at T+1 with 0x00000000; cache unchanged.
- MULHU 5 x 7 with flush_i at T+10: mul_cancel_o pulse at T+10, no res_valid_o, IDLE at T+11. Re-issuing the same op misses the cache, starts the multiplier, and yields 0x00000000.
- rst_n low at T+20 of a multiply: all outputs 0 immediately. After release, a MUL with the previous operands misses the cache and takes the full 34 cycles.
